// File: rtl/jtgng_vga_pkg.sv
// Shared state encoding and default timing for the VGA line-doubling scan controller.
package jtgng_vga_pkg;

  // One horizontal VGA line walks these states in order, wrapping back to StSync.
  typedef enum logic [2:0] {
    StSync,
    StFront,
    StLeft,
    StActive,
    StRight,
    StBack
  } vga_state_e;

  // Default horizontal timing in clk_vga cycles (800 per line without waiting).
  localparam int unsigned DefHsLen    = 96;
  localparam int unsigned DefFrontLen = 16;
  localparam int unsigned DefLeftLen  = 64;
  localparam int unsigned DefActLen   = 512;
  localparam int unsigned DefRightLen = 64;
  localparam int unsigned DefBackLen  = 48;
  localparam int unsigned DefVsLines  = 2;
  localparam int unsigned DefWaitMax  = 255;

  // Counter widths: the longest state is a wait-mode SYNC (HS_LEN + WAIT_MAX).
  localparam int unsigned CntW   = 16;
  localparam int unsigned VsCntW = 8;
  // {rd_addr, double} pixel phase counter.
  localparam int unsigned PixW   = 9;

endpackage

// File: rtl/jtgng_vga_ctrl.sv
// VGA scan controller: replays each source line twice at VGA rate, locking every
// second line to the source hblank and generating hsync/vsync and line-buffer reads.
module jtgng_vga_ctrl
  import jtgng_vga_pkg::*;
#(
  parameter int unsigned HS_LEN    = DefHsLen,
  parameter int unsigned FRONT_LEN = DefFrontLen,
  parameter int unsigned LEFT_LEN  = DefLeftLen,
  parameter int unsigned ACT_LEN   = DefActLen,
  parameter int unsigned RIGHT_LEN = DefRightLen,
  parameter int unsigned BACK_LEN  = DefBackLen,
  parameter int unsigned VS_LINES  = DefVsLines,
  parameter int unsigned WAIT_MAX  = DefWaitMax
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic       LHBL_s,
  input  logic       LVBL_s,
  output logic [7:0] rd_addr,
  output logic       double,
  output logic       rd_sel,
  output logic       scanline,
  output logic       line_active,
  output logic       vga_hsync,
  output logic       vga_vsync
);

  localparam logic [CntW-1:0]   HsLast    = CntW'(HS_LEN - 1);
  // Wait-mode SYNC runs one long countdown; the source edge may end it once the
  // count has dropped into the last WAIT_MAX+1 values (i.e. after HS_LEN-1 cycles).
  localparam logic [CntW-1:0]   WaitLast  = CntW'(HS_LEN + WAIT_MAX - 1);
  localparam logic [CntW-1:0]   WaitOpen  = CntW'(WAIT_MAX);
  localparam logic [CntW-1:0]   FrontLast = CntW'(FRONT_LEN - 1);
  localparam logic [CntW-1:0]   LeftLast  = CntW'(LEFT_LEN - 1);
  localparam logic [CntW-1:0]   ActLast   = CntW'(ACT_LEN - 1);
  localparam logic [CntW-1:0]   RightLast = CntW'(RIGHT_LEN - 1);
  localparam logic [CntW-1:0]   BackLast  = CntW'(BACK_LEN - 1);
  localparam logic [VsCntW-1:0] VsLoad    = VsCntW'(VS_LINES);

  vga_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wait_mode_q, rd_sel_q, scanline_q;
  logic              lhbl_last_q, lvbl_last_q;
  logic              lhbl_rise, lvbl_fall;
  logic              sync_exit, back_exit, front_exit;
  logic [PixW-1:0]   pix_q, pix_d;
  logic              line_active_q, hsync_q;
  logic              vsync_q, vsync_d, vsync_req_q, vsync_req_d;
  logic [VsCntW-1:0] vs_cnt_q, vs_cnt_d;

  assign lhbl_rise = LHBL_s & ~lhbl_last_q;
  assign lvbl_fall = ~LVBL_s & lvbl_last_q;

  // Next-state and per-state countdown; each state ends on the cycle its count is zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - CntW'(1);
    sync_exit  = 1'b0;
    back_exit  = 1'b0;
    front_exit = 1'b0;
    unique case (state_q)
      StSync: begin
        if ((cnt_q == '0) || (wait_mode_q && (cnt_q <= WaitOpen) && lhbl_rise)) begin
          state_d   = StFront;
          cnt_d     = FrontLast;
          sync_exit = 1'b1;
        end
      end
      StFront: begin
        if (cnt_q == '0) begin
          state_d    = StLeft;
          cnt_d      = LeftLast;
          front_exit = 1'b1;
        end
      end
      StLeft: begin
        if (cnt_q == '0) begin
          state_d = StActive;
          cnt_d   = ActLast;
        end
      end
      StActive: begin
        if (cnt_q == '0) begin
          state_d = StRight;
          cnt_d   = RightLast;
        end
      end
      StRight: begin
        if (cnt_q == '0) begin
          state_d = StBack;
          cnt_d   = BackLast;
        end
      end
      StBack: begin
        if (cnt_q == '0) begin
          state_d   = StSync;
          // wait_mode_q has already flipped for the line that is starting.
          cnt_d     = wait_mode_q ? WaitLast : HsLast;
          back_exit = 1'b1;
        end
      end
      default: begin
        state_d = StSync;
        cnt_d   = HsLast;
      end
    endcase
  end

  // State register, line-pair bookkeeping and input edge history.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSync;
      cnt_q       <= HsLast;
      wait_mode_q <= 1'b0;
      rd_sel_q    <= 1'b0;
      scanline_q  <= 1'b0;
      lhbl_last_q <= 1'b1;
      lvbl_last_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lhbl_last_q <= LHBL_s;
      lvbl_last_q <= LVBL_s;
      if (sync_exit) begin
        wait_mode_q <= ~wait_mode_q;
        // Swap buffers once per line pair, at the end of the locked line's sync.
        if (wait_mode_q) rd_sel_q <= ~rd_sel_q;
      end
      if (front_exit) scanline_q <= ~scanline_q;
    end
  end

  // Pixel phase: counts through the active window, zero everywhere else.
  always_comb begin
    pix_d = '0;
    if (state_d == StActive && state_q == StActive) pix_d = pix_q + PixW'(1);
  end

  // Registered line outputs, aligned with the registered state.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      pix_q         <= '0;
      line_active_q <= 1'b0;
      hsync_q       <= 1'b1;
    end else begin
      pix_q         <= pix_d;
      line_active_q <= (state_d == StActive);
      hsync_q       <= (state_d != StSync);
    end
  end

  // Vsync request latch and line counter; edges during an active vsync are dropped.
  always_comb begin
    vsync_d     = vsync_q;
    vs_cnt_d    = vs_cnt_q;
    vsync_req_d = vsync_req_q;
    if (lvbl_fall && vsync_q) vsync_req_d = 1'b1;
    if (back_exit) begin
      if (!vsync_q) begin
        if (vs_cnt_q <= VsCntW'(1)) begin
          vsync_d  = 1'b1;
          vs_cnt_d = '0;
        end else begin
          vs_cnt_d = vs_cnt_q - VsCntW'(1);
        end
      end else if (vsync_req_q) begin
        vsync_d     = 1'b0;
        vs_cnt_d    = VsLoad;
        vsync_req_d = 1'b0;
      end
    end
  end

  // Vsync state register.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b1;
      vs_cnt_q    <= '0;
      vsync_req_q <= 1'b0;
    end else begin
      vsync_q     <= vsync_d;
      vs_cnt_q    <= vs_cnt_d;
      vsync_req_q <= vsync_req_d;
    end
  end

  assign rd_addr     = pix_q[PixW-1:1];
  assign double      = pix_q[0];
  assign rd_sel      = rd_sel_q;
  assign scanline    = scanline_q;
  assign line_active = line_active_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;

endmodule
